// File: rtl/fsm_array_pkg.sv
// Shared types and default sizing for the multi-channel accumulate FSM array.
package fsm_array_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } chan_state_e;

  localparam int unsigned NumChDefault  = 2;
  localparam int unsigned DataWDefault  = 8;
  localparam int unsigned AccWDefault   = 2 * DataWDefault;
  localparam int unsigned MaxLenDefault = 16;
  localparam bit          SatDefault    = 1'b1;

endpackage

// File: rtl/fsm_array_chan.sv
// One channel: start/stop accumulate engine with length limit, saturate-or-wrap
// arithmetic, registered result/overflow and a one-cycle done pulse.
module fsm_array_chan
  import fsm_array_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned ACC_W   = AccWDefault,
  parameter int unsigned MAX_LEN = MaxLenDefault,
  parameter bit          SAT     = SatDefault
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);
  localparam int unsigned SumW = ACC_W + 1;

  chan_state_e       state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              ovf_run_q;
  logic [ACC_W-1:0]  result_q;
  logic              ovf_q;
  logic              done_q;

  logic [ACC_W-1:0]  data_ext;
  logic [SumW-1:0]   sum;
  logic              carry;
  logic [ACC_W-1:0]  acc_add;
  logic [CntW-1:0]   cnt_inc;
  logic              at_limit;

  always_comb begin
    data_ext = ACC_W'(data_i);
    sum      = {1'b0, acc_q} + SumW'(data_i);
    carry    = sum[ACC_W];
    acc_add  = (SAT && carry) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    cnt_inc  = cnt_q + CntW'(1);
    at_limit = (cnt_inc == CntW'(MAX_LEN));
  end

  // Result/overflow/done are loaded on the edge that enters StDone so they are
  // valid during the single StDone cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_run_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            acc_q     <= data_ext;
            cnt_q     <= CntW'(1);
            ovf_run_q <= 1'b0;
            if (MAX_LEN == 1) begin
              state_q  <= StDone;
              result_q <= data_ext;
              ovf_q    <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state_q <= StAcc;
            end
          end
        end
        StAcc: begin
          if (stop_i) begin
            state_q  <= StDone;
            result_q <= acc_q;
            ovf_q    <= ovf_run_q;
            done_q   <= 1'b1;
          end else if (start_i) begin
            acc_q     <= data_ext;
            cnt_q     <= CntW'(1);
            ovf_run_q <= 1'b0;
          end else begin
            acc_q     <= acc_add;
            cnt_q     <= cnt_inc;
            ovf_run_q <= ovf_run_q | carry;
            if (at_limit) begin
              state_q  <= StDone;
              result_q <= acc_add;
              ovf_q    <= ovf_run_q | carry;
              done_q   <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: rtl/fsm_array.sv
// NUM_CH independent accumulate channels; the only shared output is any_done_o.
module fsm_array
  import fsm_array_pkg::*;
#(
  parameter int unsigned NUM_CH  = NumChDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned ACC_W   = 2 * DATA_W,
  parameter int unsigned MAX_LEN = MaxLenDefault,
  parameter bit          SAT     = SatDefault
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  data_i,
  input  logic [NUM_CH-1:0]              start_i,
  input  logic [NUM_CH-1:0]              stop_i,
  output logic [NUM_CH-1:0][ACC_W-1:0]   result_o,
  output logic [NUM_CH-1:0]              done_o,
  output logic [NUM_CH-1:0]              ovf_o,
  output logic [NUM_CH-1:0]              busy_o,
  output logic                           any_done_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    fsm_array_chan #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .MAX_LEN (MAX_LEN),
      .SAT     (SAT)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (data_i[g]),
      .start_i  (start_i[g]),
      .stop_i   (stop_i[g]),
      .result_o (result_o[g]),
      .done_o   (done_o[g]),
      .ovf_o    (ovf_o[g]),
      .busy_o   (busy_o[g])
    );
  end

  assign any_done_o = |done_o;

endmodule
